multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM for the multicycle RISC-V core. It sequences one shared ALU and one unified instruction/data memory across Fetch, Decode, Execute, Memory and Writeback cycles.
- Covers the same instruction subset as the single-cycle main decoder: lw, sw, R-type, I-type ALU, beq, jal.
- Drives register enables and mux selects for the datapath. It stalls on a memory-ready handshake.

Parameters:
- OP_W, 7, opcode field width.
- STATE_W, 4, width of the state debug port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  opcode from the instruction register (IR), stable after FETCH.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = Result.
- ir_write  out  1  IR and OldPC register enable.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = ImmExt, 10 = constant 4.
- result_src  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type funct, 11 = I-type funct.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- illegal_op  out  1  unrecognised opcode seen in DECODE.
- instr_done  out  1  last cycle of an instruction.
- state  out  4  current state (debug).

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BEQ = 9, JAL = 10. Codes 11–15 are unreachable; if entered, the next state is FETCH.
- Outputs are a Moore decode of state. The exception is that pc_write, ir_write and mem_write also depend on mem_ready/zero, as listed below.
- Every output not listed for a state is 0.
- imm_src decodes combinationally from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- Synchronous reset: the state register takes FETCH at the next clk edge while rst = 1.
  - While rst = 1, pc_write, ir_write, mem_write, reg_write, illegal_op and instr_done are forced to 0. Selects show FETCH values.
  - Reset mid-instruction abandons the instruction; no writes are issued.
- FETCH:
  - Outputs: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE:
  - Outputs: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into ALUOut).
  - Next state: lw/sw → MEMADR, R-type → EXECUTER, I-type → EXECUTEI, beq → BEQ, jal → JAL.
  - Any other op: illegal_op = 1 this cycle, next state FETCH; no architectural writes occur.
- MEMADR:
  - Outputs: alu_src_a = 10, alu_src_b = 01, alu_op = 00.
  - Next: MEMREAD if op = lw, otherwise MEMWRITE.
- MEMREAD:
  - Outputs: adr_src = 1, result_src = 00.
  - Hold until mem_ready, then go to MEMWB.
- MEMWB:
  - Outputs: result_src = 01, reg_write = 1, instr_done = 1.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: adr_src = 1, result_src = 00, mem_write = 1.
  - mem_write stays high continuously while waiting for mem_ready.
  - When mem_ready: instr_done = 1, next state FETCH.
- EXECUTER:
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 10.
  - Next: ALUWB.
- EXECUTEI:
  - Outputs: alu_src_a = 10, alu_src_b = 01, alu_op = 11.
  - Next: ALUWB.
- ALUWB:
  - Outputs: result_src = 00, reg_write = 1, instr_done = 1.
  - Next: FETCH.
- BEQ:
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00.
  - pc_write = zero, instr_done = 1.
  - Next: FETCH.
- JAL:
  - Outputs: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_write = 1 (PC ← target in ALUOut).
  - Next: ALUWB, which writes OldPC+4 into rd.
- Cycle counts with mem_ready always 1:
  - lw 5; sw 4; R-type/I-type 4; beq 3; jal 4; illegal opcode 2.
  - Each wait-state adds one cycle in FETCH, MEMREAD or MEMWRITE.

Test Plan:
1. Hold rst = 1 for 3 cycles, then release. Required: state = 0, all enables 0 during reset; the first cycle after release is FETCH with ir_write = pc_write = 1 (mem_ready = 1).
2. op = 0110011, mem_ready = 1. Required: state sequence 0, 1, 6, 8, 0; reg_write = 1 only in state 8; alu_op = 10 in state 6.
3. op = 0000011 with mem_ready low for 2 cycles in MEMREAD. Required: sequence 0, 1, 2, 3, 3, 3, 4, 0; reg_write and result_src = 01 in state 4; instr_done pulses once.
4. op = 1100011, first with zero = 1, then with zero = 0. Required: pc_write = 1 and pc_write = 0 respectively in state 9; 3 cycles each.
5. op = 1101111. Required: sequence 0, 1, 10, 8; pc_write = 1 in state 10; imm_src = 11; reg_write in state 8.
6. op = 1111111. Required: illegal_op = 1 in DECODE, next state FETCH, no reg_write/mem_write. Then assert rst during MEMWRITE of an sw: mem_write is 0 that cycle and state = FETCH next.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RISC-V core. It sequences the shared ALU and
// the unified instruction/data memory through fetch, decode, execute, memory
// and writeback, and stalls on the memory-ready handshake.
module multicycle_controller #(
    parameter int OP_W    = 7,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_op,
    output logic [1:0]         imm_src,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R    = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I    = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7'b1101111);

    state_t state_q;
    state_t state_d;

    assign state = STATE_W'(state_q);

    // State register: synchronous reset returns the sequencer to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred for state_d.
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                else if (op == OP_R)            state_d = S_EXECUTER;
                else if (op == OP_I)            state_d = S_EXECUTEI;
                else if (op == OP_BEQ)          state_d = S_BEQ;
                else if (op == OP_JAL)          state_d = S_JAL;
                else                            state_d = S_FETCH;
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src = 2'b00;
        if (op == OP_SW)       imm_src = 2'b01;
        else if (op == OP_BEQ) imm_src = 2'b10;
        else if (op == OP_JAL) imm_src = 2'b11;
    end

    // Moore output decode; reset suppresses all writes and shows FETCH selects.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal_op = !(op == OP_LW || op == OP_SW || op == OP_R ||
                               op == OP_I  || op == OP_BEQ || op == OP_JAL);
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            instr_done = 1'b0;
            adr_src    = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            alu_op     = 2'b00;
        end
    end

endmodule
